// File: rtl/hbm_vertex_arbiter_if.sv
// ---------------------------------------------------------------------------
// hbm_vertex_arbiter_if
// Bundles the requester side (MPU = index 0, VMU = index 1) and the HBM vertex
// engine side of the vertex arbiter into one interface.
//   slave  : seen by the arbiter (requests/engine status in, grants/engine
//            controls out)
//   master : seen by whoever drives the requesters and the engine model
// Signals:
//   Req/ReqWrite/ReqBurst*/ReqAddr*/WrData*/WrReady*  requester inputs
//   Gnt/Done/RdReady/WrResp/Busy/Timeout              requester-side status
//   HBM_Start*/HBM_*Burst/HBM_*Address/HBM_Write*     engine controls
//   HBM_ReadReady/HBM_EndRead/HBM_WriteResp/HBM_EndWrite  engine status
// ---------------------------------------------------------------------------
interface hbm_vertex_arbiter_if #(
  parameter int DATAWIDTH = 256
);
  logic [1:0]           Req;
  logic [1:0]           ReqWrite;
  logic [7:0]           ReqBurst0;
  logic [7:0]           ReqBurst1;
  logic [32:0]          ReqAddr0;
  logic [32:0]          ReqAddr1;
  logic [DATAWIDTH-1:0] WrData0;
  logic [DATAWIDTH-1:0] WrData1;
  logic                 WrReady0;
  logic                 WrReady1;

  logic [1:0]           Gnt;
  logic [1:0]           Done;
  logic [1:0]           RdReady;
  logic [1:0]           WrResp;
  logic                 Busy;
  logic                 Timeout;

  logic                 HBM_StartRead;
  logic                 HBM_StartWrite;
  logic [7:0]           HBM_ReadBurst;
  logic [7:0]           HBM_WriteBurst;
  logic [32:0]          HBM_ReadAddress;
  logic [32:0]          HBM_WriteAddress;
  logic [DATAWIDTH-1:0] HBM_WriteData;
  logic                 HBM_WriteReady;

  logic                 HBM_ReadReady;
  logic                 HBM_EndRead;
  logic                 HBM_WriteResp;
  logic                 HBM_EndWrite;

  modport slave (
    input  Req, ReqWrite, ReqBurst0, ReqBurst1, ReqAddr0, ReqAddr1,
           WrData0, WrData1, WrReady0, WrReady1,
           HBM_ReadReady, HBM_EndRead, HBM_WriteResp, HBM_EndWrite,
    output Gnt, Done, RdReady, WrResp, Busy, Timeout,
           HBM_StartRead, HBM_StartWrite, HBM_ReadBurst, HBM_WriteBurst,
           HBM_ReadAddress, HBM_WriteAddress, HBM_WriteData, HBM_WriteReady
  );

  modport master (
    output Req, ReqWrite, ReqBurst0, ReqBurst1, ReqAddr0, ReqAddr1,
           WrData0, WrData1, WrReady0, WrReady1,
           HBM_ReadReady, HBM_EndRead, HBM_WriteResp, HBM_EndWrite,
    input  Gnt, Done, RdReady, WrResp, Busy, Timeout,
           HBM_StartRead, HBM_StartWrite, HBM_ReadBurst, HBM_WriteBurst,
           HBM_ReadAddress, HBM_WriteAddress, HBM_WriteData, HBM_WriteReady
  );
endinterface

// File: rtl/hbm_vertex_arbiter.sv
// ---------------------------------------------------------------------------
// hbm_vertex_arbiter
// Shares the single HBM vertex AXI master engine between the MPU (requester 0)
// and the VMU (requester 1) with registered, round-robin, transaction-level
// arbitration. A grant is held from the engine start until EndRead/EndWrite of
// the granted op; engine status and write beats are routed to the owner only.
// A watchdog aborts a transaction that never ends and sets a sticky Timeout.
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    hbm_vertex_arbiter_if.slave (requester and engine signals)
// Parameters:
//   DATAWIDTH   vertex beat width
//   TIMEOUT     max cycles in WAIT_END before abort, 0 disables the watchdog
//   FIRST_PRIO  requester that wins a simultaneous request after reset
// ---------------------------------------------------------------------------
module hbm_vertex_arbiter #(
  parameter int   DATAWIDTH  = 256,
  parameter int   TIMEOUT    = 4096,
  parameter logic FIRST_PRIO = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  hbm_vertex_arbiter_if.slave bus
);

  // Counter is sized so it can hold TIMEOUT; keep at least one bit when the
  // watchdog is disabled.
  localparam int CNTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNTW-1:0] WD_LAST = CNTW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNTW-1:0] WD_MAX  = '1;
  localparam logic            WD_ON   = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_END = 2'd2,
    RELEASE  = 2'd3
  } arbState_t;

  arbState_t            state;
  logic                 owner;
  logic                 opWrite;
  logic                 last;
  logic [CNTW-1:0]      wdCount;
  logic [1:0]           gntReg;
  logic [1:0]           doneReg;
  logic                 timeoutReg;
  logic                 startReadReg;
  logic                 startWriteReg;
  logic [7:0]           readBurstReg;
  logic [7:0]           writeBurstReg;
  logic [32:0]          readAddrReg;
  logic [32:0]          writeAddrReg;

  logic                 winner;
  logic                 endHit;
  logic                 wdExpire;
  logic [1:0]           rdReadyRoute;
  logic [1:0]           wrRespRoute;
  logic [DATAWIDTH-1:0] writeData;

  // Round robin: a lone requester always wins, a tie goes to whoever was not
  // served last.
  assign winner   = (bus.Req == 2'b11) ? ~last : bus.Req[1];
  // Only the End of the granted op type terminates the transaction.
  assign endHit   = opWrite ? bus.HBM_EndWrite : bus.HBM_EndRead;
  assign wdExpire = WD_ON && (wdCount == WD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= 1'b0;
      opWrite       <= 1'b0;
      last          <= ~FIRST_PRIO;
      wdCount       <= '0;
      gntReg        <= 2'b00;
      doneReg       <= 2'b00;
      timeoutReg    <= 1'b0;
      startReadReg  <= 1'b0;
      startWriteReg <= 1'b0;
      readBurstReg  <= '0;
      writeBurstReg <= '0;
      readAddrReg   <= '0;
      writeAddrReg  <= '0;
    end else begin
      // Start and Done are single-cycle pulses.
      startReadReg  <= 1'b0;
      startWriteReg <= 1'b0;
      doneReg       <= 2'b00;
      case (state)
        IDLE: begin
          if (|bus.Req) begin
            owner   <= winner;
            last    <= winner;
            opWrite <= bus.ReqWrite[winner];
            gntReg  <= winner ? 2'b10 : 2'b01;
            if (bus.ReqWrite[winner]) begin
              writeAddrReg  <= winner ? bus.ReqAddr1 : bus.ReqAddr0;
              writeBurstReg <= winner ? bus.ReqBurst1 : bus.ReqBurst0;
              startWriteReg <= 1'b1;
            end else begin
              readAddrReg   <= winner ? bus.ReqAddr1 : bus.ReqAddr0;
              readBurstReg  <= winner ? bus.ReqBurst1 : bus.ReqBurst0;
              startReadReg  <= 1'b1;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          wdCount <= '0;
          // A very short engine transaction may already end in the start cycle.
          if (endHit) begin
            doneReg <= owner ? 2'b10 : 2'b01;
            gntReg  <= 2'b00;
            state   <= RELEASE;
          end else begin
            state   <= WAIT_END;
          end
        end
        WAIT_END: begin
          if (endHit) begin
            doneReg <= owner ? 2'b10 : 2'b01;
            gntReg  <= 2'b00;
            state   <= RELEASE;
          end else if (wdExpire) begin
            // Abort silently: the owner gets no Done, only the sticky flag.
            timeoutReg <= 1'b1;
            gntReg     <= 2'b00;
            state      <= RELEASE;
          end else if (wdCount != WD_MAX) begin
            wdCount <= wdCount + 1'b1;
          end
        end
        RELEASE: begin
          // One dead cycle so consecutive engine starts are spaced apart.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Engine status goes only to the current grant owner.
  for (genvar gi = 0; gi < 2; gi++) begin : g_route
    assign rdReadyRoute[gi] = bus.HBM_ReadReady & gntReg[gi];
    assign wrRespRoute[gi]  = bus.HBM_WriteResp & gntReg[gi];
  end

  always_comb begin
    writeData = '0;
    if (gntReg[1]) begin
      writeData = bus.WrData1;
    end else if (gntReg[0]) begin
      writeData = bus.WrData0;
    end
  end

  assign bus.Gnt              = gntReg;
  assign bus.Done             = doneReg;
  assign bus.RdReady          = rdReadyRoute;
  assign bus.WrResp           = wrRespRoute;
  assign bus.Busy             = (state != IDLE);
  assign bus.Timeout          = timeoutReg;
  assign bus.HBM_StartRead    = startReadReg;
  assign bus.HBM_StartWrite   = startWriteReg;
  assign bus.HBM_ReadBurst    = readBurstReg;
  assign bus.HBM_WriteBurst   = writeBurstReg;
  assign bus.HBM_ReadAddress  = readAddrReg;
  assign bus.HBM_WriteAddress = writeAddrReg;
  assign bus.HBM_WriteData    = writeData;
  assign bus.HBM_WriteReady   = opWrite &
                                ((gntReg[0] & bus.WrReady0) | (gntReg[1] & bus.WrReady1));

endmodule

// File: tb/tb_hbm_vertex_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hbm_vertex_arbiter
// Directed bench for hbm_vertex_arbiter: a table of per-cycle vectors
// followed by hand-written sequences for address latching, watchdog abort,
// reset mid-transaction, round-robin alternation and write-beat routing.
// ---------------------------------------------------------------------------
module tb_hbm_vertex_arbiter;
  localparam int DW = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hbm_vertex_arbiter_if #(.DATAWIDTH(DW)) bus ();

  hbm_vertex_arbiter #(
    .DATAWIDTH (DW),
    .TIMEOUT   (16),
    .FIRST_PRIO(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [1:0] req;
    logic [1:0] wr;
    logic       endRd;
    logic       endWr;
    logic       rdy;
    logic       resp;
    logic       wr0;
    logic       wr1;
    logic [11:0] expOut;  // {Gnt, Done, StartRead, StartWrite, Busy, RdReady, WrResp, WriteReady}
  } vec_t;

  vec_t vecs[19];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] req, input logic [1:0] wr,
                              input logic endRd, input logic endWr, input logic rdy,
                              input logic resp, input logic wr0, input logic wr1,
                              input logic [1:0] gnt, input logic [1:0] done,
                              input logic stR, input logic stW, input logic busy,
                              input logic [1:0] rdReady, input logic [1:0] wrResp,
                              input logic wrRdy);
    vec_t v;
    v.req = req; v.wr = wr; v.endRd = endRd; v.endWr = endWr;
    v.rdy = rdy; v.resp = resp; v.wr0 = wr0; v.wr1 = wr1;
    v.expOut = {gnt, done, stR, stW, busy, rdReady, wrResp, wrRdy};
    return v;
  endfunction

  function automatic logic [11:0] actOut();
    return {bus.Gnt, bus.Done, bus.HBM_StartRead, bus.HBM_StartWrite, bus.Busy,
            bus.RdReady, bus.WrResp, bus.HBM_WriteReady};
  endfunction

  task automatic clearInputs();
    bus.Req = 2'b00; bus.ReqWrite = 2'b00;
    bus.HBM_EndRead = 1'b0; bus.HBM_EndWrite = 1'b0;
    bus.HBM_ReadReady = 1'b0; bus.HBM_WriteResp = 1'b0;
    bus.WrReady0 = 1'b0; bus.WrReady1 = 1'b0;
  endtask

  initial begin
    int n;
    logic seenDone;
    logic [1:0] expGnt;
    logic [DW-1:0] beat;

    //        req   wr    eR eW rdy rsp w0 w1 | gnt   done  sR sW by rdR   wrR   wRdy
    vecs[0]  = mk(2'b00,2'b00,0,0,0,0,0,0, 2'b00,2'b00,0,0,0,2'b00,2'b00,0);
    vecs[1]  = mk(2'b01,2'b00,0,0,0,0,0,0, 2'b01,2'b00,1,0,1,2'b00,2'b00,0);
    vecs[2]  = mk(2'b00,2'b00,0,0,1,0,0,0, 2'b01,2'b00,0,0,1,2'b01,2'b00,0);
    vecs[3]  = mk(2'b00,2'b00,0,1,1,1,0,0, 2'b01,2'b00,0,0,1,2'b01,2'b01,0);
    vecs[4]  = mk(2'b00,2'b00,1,0,0,0,0,0, 2'b00,2'b01,0,0,1,2'b00,2'b00,0);
    vecs[5]  = mk(2'b10,2'b10,0,0,0,0,0,0, 2'b00,2'b00,0,0,0,2'b00,2'b00,0);
    vecs[6]  = mk(2'b10,2'b10,0,0,0,0,0,0, 2'b10,2'b00,0,1,1,2'b00,2'b00,0);
    vecs[7]  = mk(2'b00,2'b10,0,0,0,0,1,1, 2'b10,2'b00,0,0,1,2'b00,2'b00,1);
    vecs[8]  = mk(2'b00,2'b10,0,0,1,1,1,0, 2'b10,2'b00,0,0,1,2'b10,2'b10,0);
    vecs[9]  = mk(2'b00,2'b10,1,0,0,0,0,0, 2'b10,2'b00,0,0,1,2'b00,2'b00,0);
    vecs[10] = mk(2'b00,2'b10,0,1,0,0,0,0, 2'b00,2'b10,0,0,1,2'b00,2'b00,0);
    vecs[11] = mk(2'b11,2'b00,0,0,0,0,0,0, 2'b00,2'b00,0,0,0,2'b00,2'b00,0);
    vecs[12] = mk(2'b11,2'b00,0,0,0,0,0,0, 2'b01,2'b00,1,0,1,2'b00,2'b00,0);
    vecs[13] = mk(2'b10,2'b00,1,0,0,0,0,0, 2'b00,2'b01,0,0,1,2'b00,2'b00,0);
    vecs[14] = mk(2'b10,2'b00,0,0,0,0,0,0, 2'b00,2'b00,0,0,0,2'b00,2'b00,0);
    vecs[15] = mk(2'b00,2'b00,0,0,0,0,0,0, 2'b00,2'b00,0,0,0,2'b00,2'b00,0);
    vecs[16] = mk(2'b01,2'b01,0,0,0,0,0,0, 2'b01,2'b00,0,1,1,2'b00,2'b00,0);
    vecs[17] = mk(2'b00,2'b01,0,1,0,0,0,0, 2'b00,2'b01,0,0,1,2'b00,2'b00,0);
    vecs[18] = mk(2'b00,2'b00,0,0,0,0,0,0, 2'b00,2'b00,0,0,0,2'b00,2'b00,0);

    clearInputs();
    bus.ReqAddr0 = 33'h100;  bus.ReqBurst0 = 8'd4;
    bus.ReqAddr1 = 33'h2000; bus.ReqBurst1 = 8'd8;
    bus.WrData0  = {8{32'hAAAA0000}};
    bus.WrData1  = {8{32'h55550000}};
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("rst_gnt", DW'(bus.Gnt), '0);
    check("rst_done", DW'(bus.Done), '0);
    check("rst_start", DW'({bus.HBM_StartRead, bus.HBM_StartWrite}), '0);
    check("rst_busy_to", DW'({bus.Busy, bus.Timeout}), '0);
    check("rst_addr", DW'({bus.HBM_ReadAddress, bus.HBM_WriteAddress}), '0);
    check("rst_burst", DW'({bus.HBM_ReadBurst, bus.HBM_WriteBurst}), '0);

    // Table-driven cycle vectors
    for (int i = 0; i < 19; i++) begin
      bus.Req = vecs[i].req; bus.ReqWrite = vecs[i].wr;
      bus.HBM_EndRead = vecs[i].endRd; bus.HBM_EndWrite = vecs[i].endWr;
      bus.HBM_ReadReady = vecs[i].rdy; bus.HBM_WriteResp = vecs[i].resp;
      bus.WrReady0 = vecs[i].wr0; bus.WrReady1 = vecs[i].wr1;
      tick();
      check($sformatf("vec%0d", i), DW'(actOut()), DW'(vecs[i].expOut));
    end
    clearInputs();

    // MPU read 0x100 burst 4; address stays latched after requester inputs move
    bus.Req = 2'b01;
    tick();
    check("rd_gnt", DW'(bus.Gnt), DW'(2'b01));
    check("rd_start", DW'({bus.HBM_StartRead, bus.HBM_StartWrite}), DW'(2'b10));
    check("rd_addr", DW'(bus.HBM_ReadAddress), DW'(33'h100));
    check("rd_burst", DW'(bus.HBM_ReadBurst), DW'(8'd4));
    bus.Req = 2'b00; bus.ReqAddr0 = 33'h1FF; bus.ReqBurst0 = 8'd9;
    tick();
    check("rd_addr_hold", DW'({bus.HBM_ReadAddress, bus.HBM_ReadBurst}), DW'({33'h100, 8'd4}));
    check("rd_start_off", DW'(bus.HBM_StartRead), '0);
    bus.HBM_EndRead = 1'b1;
    tick();
    check("rd_done", DW'(bus.Done), DW'(2'b01));
    bus.HBM_EndRead = 1'b0;
    tick();
    tick();

    // Watchdog: no end for a read, abort after 16 cycles in WAIT_END
    bus.Req = 2'b01;
    tick();
    check("wd_gnt", DW'(bus.Gnt), DW'(2'b01));
    bus.Req = 2'b00;
    n = 0; seenDone = 1'b0;
    while (bus.Timeout !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (bus.Done != 2'b00) seenDone = 1'b1;
    end
    check("wd_cycles", DW'(n), DW'(17));
    check("wd_nodone", DW'(seenDone), '0);
    check("wd_gnt_clr", DW'(bus.Gnt), '0);
    bus.Req = 2'b10;
    tick();
    tick();
    check("wd_next_gnt", DW'(bus.Gnt), DW'(2'b10));
    check("wd_sticky", DW'(bus.Timeout), DW'(1'b1));
    bus.Req = 2'b00;
    tick();

    // Reset during WAIT_END
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_state", DW'({bus.Gnt, bus.Busy, bus.Timeout, bus.Done}), '0);
    bus.HBM_EndRead = 1'b1;
    tick();
    check("stray_end_done", DW'({bus.Done, bus.Gnt}), '0);
    bus.HBM_EndRead = 1'b0;
    tick();
    check("stray_end_done2", DW'({bus.Done, bus.Gnt}), '0);

    // Both held requesting: VMU first after reset, then strict alternation
    bus.Req = 2'b11; bus.ReqWrite = 2'b00;
    for (int k = 0; k < 6; k++) begin
      expGnt = (k % 2 == 0) ? 2'b10 : 2'b01;
      n = 0;
      while (bus.Gnt == 2'b00 && n < 10) begin
        tick();
        n++;
      end
      check($sformatf("rr_gnt%0d", k), DW'(bus.Gnt), DW'(expGnt));
      if (k > 0) check($sformatf("rr_gap%0d", k), DW'(n), DW'(2));
      tick();
      bus.HBM_EndRead = 1'b1;
      tick();
      bus.HBM_EndRead = 1'b0;
      check($sformatf("rr_done%0d", k), DW'({bus.Done, bus.Gnt}), DW'({expGnt, 2'b00}));
    end

    // VMU write: only WrData1/WrReady1 reach the engine, MPU status stays 0
    bus.Req = 2'b10; bus.ReqWrite = 2'b10;
    n = 0;
    while (bus.Gnt == 2'b00 && n < 10) begin
      tick();
      n++;
    end
    check("wr_gnt", DW'(bus.Gnt), DW'(2'b10));
    check("wr_start", DW'({bus.HBM_StartRead, bus.HBM_StartWrite}), DW'(2'b01));
    bus.Req = 2'b00;
    tick();
    for (int b = 0; b < 4; b++) begin
      beat = {8{32'hC0DE0000 + 32'(b)}};
      bus.WrData1 = beat; bus.WrReady1 = 1'b1;
      bus.WrData0 = ~beat; bus.WrReady0 = 1'b1;
      bus.HBM_ReadReady = 1'b1; bus.HBM_WriteResp = 1'b1;
      #1;
      check($sformatf("wr_data%0d", b), bus.HBM_WriteData, beat);
      check($sformatf("wr_rdy%0d", b), DW'(bus.HBM_WriteReady), DW'(1'b1));
      check($sformatf("wr_mpu_stat%0d", b), DW'({bus.RdReady[0], bus.WrResp[0]}), '0);
      tick();
    end
    bus.WrReady1 = 1'b0; bus.WrReady0 = 1'b1;
    #1;
    check("wr_mpu_beat_blocked", DW'(bus.HBM_WriteReady), '0);
    bus.WrReady0 = 1'b0; bus.HBM_ReadReady = 1'b0; bus.HBM_WriteResp = 1'b0;
    bus.HBM_EndWrite = 1'b1;
    tick();
    check("wr_done", DW'(bus.Done), DW'(2'b10));
    bus.HBM_EndWrite = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end
endmodule
